hsid_mse: RTL and testbench

Mean-squared-error engine that sits directly downstream of the main HSI library state machine's `HM_COMPUTE_MSE` state and feeds its `HM_WAIT_MSE` / `HM_COMPARE_MSE` states. For one captured pixel versus one library pixel it consumes band pairs over a valid/ready stream. It computes the squared difference per band through a 3-stage pipeline and accumulates over the configured band count. It then returns one tagged error value per library pixel for the comparator to pick the minimum.

---
 rtl/hsid_pkg.sv | 20 ++
 rtl/hsid_div_seq.sv | 72 +++++++
 rtl/hsid_mse.sv | 195 +++++++++++++++++++
 tb/tb_hsid_mse.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// Shared widths and state encodings for the HSI library matching datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hsid_pkg;

    localparam int HSID_DATA_WIDTH        = 16;
    localparam int HSID_DATA_WIDTH_MUL    = 32;
    localparam int HSID_DATA_WIDTH_ACC    = 40;
    localparam int HSID_HSP_BANDS_WIDTH   = 7;
    localparam int HSID_HSP_LIBRARY_WIDTH = 6;

    // MSE engine sequencing; MSE_DIV is only reachable when the mean divider is built.
    typedef enum logic [1:0] {
        MSE_IDLE    = 2'd0,
        MSE_COMPUTE = 2'd1,
        MSE_DRAIN   = 2'd2,
        MSE_DIV     = 2'd3
    } hsid_mse_state_t;

endpackage

// File: rtl/hsid_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: DIVIDEND_WIDTH cycles after start_i; done_o/quotient_o are valid combinationally in the final step cycle.
// Backpressure: none; a new start_i restarts the division, rst_i aborts it.
module hsid_div_seq
    import hsid_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = HSID_DATA_WIDTH_ACC,
    parameter int DIVISOR_WIDTH  = HSID_HSP_BANDS_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    output logic                      done_o,
    output logic [DIVIDEND_WIDTH-1:0] quotient_o
);

    localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

    logic                      busy_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DIVISOR_WIDTH-1:0]  rem_q;
    logic [DIVISOR_WIDTH-1:0]  divisor_q;
    logic [DIVIDEND_WIDTH-1:0] quo_q;

    logic [DIVISOR_WIDTH:0]    rem_sh;
    logic                      rem_ge;
    logic [DIVISOR_WIDTH-1:0]  rem_nxt;
    logic [DIVIDEND_WIDTH-1:0] quo_nxt;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The remainder always stays below the
    // divisor, so it never needs more than DIVISOR_WIDTH bits between steps.
    always_comb begin
        rem_sh  = {rem_q, quo_q[DIVIDEND_WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, divisor_q});
        rem_nxt = rem_sh[DIVISOR_WIDTH-1:0];
        if (rem_ge) begin
            rem_nxt = DIVISOR_WIDTH'(rem_sh - {1'b0, divisor_q});
        end
        quo_nxt = {quo_q[DIVIDEND_WIDTH-2:0], rem_ge};
    end

    assign done_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_o = quo_nxt;

    // Load operands on start, then iterate until every dividend bit has been consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            cnt_q     <= CNT_W'(DIVIDEND_WIDTH);
            rem_q     <= '0;
            divisor_q <= divisor_i;
            quo_q     <= dividend_i;
        end else if (busy_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hsid_mse.sv
// Per-library-pixel squared-error engine: 3-stage diff/square/accumulate over a band stream.
// Latency: last band handshake at t -> mse_valid_o at t+3 (t+43 with HSID_MSE_MEAN_EN dividing by band count).
// Backpressure: band_ready_o is high only in MSE_COMPUTE; one band per cycle, no internal stalls.
module hsid_mse
    import hsid_pkg::*;
#(
    parameter int DATA_WIDTH        = HSID_DATA_WIDTH,
    parameter int DATA_WIDTH_MUL    = HSID_DATA_WIDTH_MUL,
    parameter int DATA_WIDTH_ACC    = HSID_DATA_WIDTH_ACC,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands_i,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_id_i,
    input  logic                         band_valid_i,
    output logic                         band_ready_o,
    input  logic [DATA_WIDTH-1:0]        hsp_ref_i,
    input  logic [DATA_WIDTH-1:0]        hsp_lib_i,
    output logic                         mse_valid_o,
    output logic [DATA_WIDTH_ACC-1:0]    mse_value_o,
    output logic [HSP_LIBRARY_WIDTH-1:0] mse_id_o,
    output logic                         busy_o,
    output logic                         error_o
);

    hsid_mse_state_t state_q, state_d;

    logic                        clr;
    logic                        idle;
    logic                        start_ok;
    logic                        start_bad;
    logic                        hs;
    logic                        last_band;
    logic                        drain_done;
    logic                        result_done;
    logic [DATA_WIDTH_ACC-1:0]   result_val;

    logic [HSP_BANDS_WIDTH-1:0]  bands_q;
    logic [HSP_BANDS_WIDTH-1:0]  cnt_q;

    logic                        s1_vld, s1_last;
    logic [DATA_WIDTH:0]         s1_diff;
    logic signed [2*DATA_WIDTH+1:0] diff_ext;
    logic                        s2_vld, s2_last;
    logic [DATA_WIDTH_MUL-1:0]   s2_sq;
    logic [DATA_WIDTH_ACC-1:0]   acc_q;
    logic [DATA_WIDTH_ACC-1:0]   acc_nxt;
    logic                        mse_valid_q;

    assign clr        = rst_i || clear_i;
    assign idle       = (state_q == MSE_IDLE);
    assign start_ok   = idle && start_i && (hsp_bands_i != '0);
    assign start_bad  = idle && start_i && (hsp_bands_i == '0);
    assign band_ready_o = (state_q == MSE_COMPUTE);
    assign busy_o     = !idle;
    assign hs         = band_valid_i && band_ready_o;
    assign last_band  = hs && (cnt_q == bands_q - HSP_BANDS_WIDTH'(1));
    assign drain_done = (state_q == MSE_DRAIN) && s2_vld && s2_last;

    // Sign-extend the difference so the square is formed at full precision before truncation.
    assign diff_ext = {{(DATA_WIDTH+1){s1_diff[DATA_WIDTH]}}, s1_diff};
    assign acc_nxt  = s2_vld ? (acc_q + DATA_WIDTH_ACC'(s2_sq)) : acc_q;

`ifdef HSID_MSE_MEAN_EN
    logic                      div_done;
    logic [DATA_WIDTH_ACC-1:0] div_quo;

    // The divider is loaded with the final sum in the same cycle the last square lands.
    hsid_div_seq #(
        .DIVIDEND_WIDTH (DATA_WIDTH_ACC),
        .DIVISOR_WIDTH  (HSP_BANDS_WIDTH)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (clr),
        .start_i    (drain_done),
        .dividend_i (acc_nxt),
        .divisor_i  (bands_q),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    assign result_done = (state_q == MSE_DIV) && div_done;
    assign result_val  = div_quo;
`else
    assign result_done = drain_done;
    assign result_val  = acc_nxt;
`endif

    // State register; clear behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            state_q <= MSE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing: idle -> stream bands -> drain pipeline -> (divide) -> idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MSE_IDLE:    if (start_ok)   state_d = MSE_COMPUTE;
            MSE_COMPUTE: if (last_band)  state_d = MSE_DRAIN;
`ifdef HSID_MSE_MEAN_EN
            MSE_DRAIN:   if (drain_done) state_d = MSE_DIV;
            MSE_DIV:     if (div_done)   state_d = MSE_IDLE;
`else
            MSE_DRAIN:   if (drain_done) state_d = MSE_IDLE;
            MSE_DIV:                     state_d = MSE_IDLE;
`endif
            default:                     state_d = MSE_IDLE;
        endcase
    end

    // Job context: band count latched on accepted start, handshake counter from zero.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            bands_q <= '0;
            cnt_q   <= '0;
        end else if (start_ok) begin
            bands_q <= hsp_bands_i;
            cnt_q   <= '0;
        end else if (hs) begin
            cnt_q   <= cnt_q + HSP_BANDS_WIDTH'(1);
        end
    end

    // Stage 1: signed difference of the accepted band pair, tagged with last-band.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_diff <= '0;
        end else begin
            s1_vld  <= hs;
            s1_last <= last_band;
            if (hs) begin
                s1_diff <= {1'b0, hsp_ref_i} - {1'b0, hsp_lib_i};
            end
        end
    end

    // Stage 2: square of the difference, truncated to the multiplier width.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_sq   <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            if (s1_vld) begin
                s2_sq <= DATA_WIDTH_MUL'(diff_ext * diff_ext);
            end
        end
    end

    // Stage 3: running sum of squares, restarted by every accepted start.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            acc_q <= '0;
        end else if (start_ok) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_nxt;
        end
    end

    // Result registers: value/id hold until the next accepted start; valid and error are pulses.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            mse_valid_q <= 1'b0;
            mse_value_o <= '0;
            mse_id_o    <= '0;
            error_o     <= 1'b0;
        end else begin
            mse_valid_q <= result_done;
            error_o     <= start_bad;
            if (start_ok) begin
                mse_value_o <= '0;
                mse_id_o    <= hsp_id_i;
            end else if (result_done) begin
                mse_value_o <= result_val;
            end
        end
    end

    // A clear arriving in the pulse cycle itself still kills the pulse.
    assign mse_valid_o = mse_valid_q && !clr;

endmodule

// File: tb/tb_hsid_mse.sv
module tb_hsid_mse;
    import hsid_pkg::*;

`ifdef HSID_MSE_MEAN_EN
    localparam int LAT  = 43;
    localparam bit MEAN = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit MEAN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  hsp_bands = '0;
    logic [5:0]  hsp_id = '0;
    logic        band_valid = 1'b0;
    logic        band_ready;
    logic [15:0] hsp_ref = '0;
    logic [15:0] hsp_lib = '0;
    logic        mse_valid;
    logic [39:0] mse_value;
    logic [5:0]  mse_id;
    logic        busy;
    logic        error;

    hsid_mse dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .start_i      (start),
        .hsp_bands_i  (hsp_bands),
        .hsp_id_i     (hsp_id),
        .band_valid_i (band_valid),
        .band_ready_o (band_ready),
        .hsp_ref_i    (hsp_ref),
        .hsp_lib_i    (hsp_lib),
        .mse_valid_o  (mse_valid),
        .mse_value_o  (mse_value),
        .mse_id_o     (mse_id),
        .busy_o       (busy),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [15:0] ref_arr [128];
    logic [15:0] lib_arr [128];

    typedef struct {
        int     bands;
        int     id;
        int     ref_v;
        int     lib_v;
        longint sse;
        longint mean;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: sum of squared differences, optionally floored mean.
    function automatic longint model(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) begin
            longint d = longint'(ref_arr[i]) - longint'(lib_arr[i]);
            s += d * d;
        end
        if (MEAN) return s / n;
        return s;
    endfunction

    task automatic no_valid(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (mse_valid) seen++;
        end
        chk(name, seen, 0);
    endtask

    // Called at a negedge; drives one complete job and checks its result.
    task automatic run_job(input string name, input int n, input int id, input int stall_at,
                           input int stall_len, input int ign_at, input longint exp_val);
        int k;
        start = 1'b1; hsp_bands = 7'(n); hsp_id = 6'(id);
        @(negedge clk);
        start = 1'b0;
        chk({name, " ready_after_start"}, longint'(band_ready), 1);
        chk({name, " value_cleared"}, longint'(mse_value), 0);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                band_valid = 1'b0;
                repeat (stall_len) @(negedge clk);
            end
            band_valid = 1'b1; hsp_ref = ref_arr[i]; hsp_lib = lib_arr[i];
            if (i == ign_at) begin
                start = 1'b1; hsp_id = 6'(id + 1);
            end
            @(negedge clk);
            start = 1'b0; hsp_id = 6'(id);
        end
        band_valid = 1'b0;
        hsp_ref = 16'($urandom); hsp_lib = 16'($urandom);
        chk({name, " ready_dropped"}, longint'(band_ready), 0);
        k = 1;
        while (!mse_valid && k < LAT + 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, " latency"}, k, LAT);
        chk({name, " value"}, longint'(mse_value), exp_val);
        chk({name, " id"}, longint'(mse_id), id);
        chk({name, " idle_at_valid"}, longint'(busy), 0);
        @(negedge clk);
        chk({name, " pulse_one_cycle"}, longint'(mse_valid), 0);
        chk({name, " value_held"}, longint'(mse_value), exp_val);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{bands: 1,   id: 5, ref_v: 100,   lib_v: 40,    sse: 64'd3600,        mean: 64'd3600};
        vecs[1] = '{bands: 127, id: 1, ref_v: 16383, lib_v: 0,     sse: 64'd34087141503, mean: 64'd268402689};
        vecs[2] = '{bands: 3,   id: 2, ref_v: 5,     lib_v: 9,     sse: 64'd48,          mean: 64'd16};
        vecs[3] = '{bands: 2,   id: 63, ref_v: 0,    lib_v: 65535, sse: 64'd8589672450,  mean: 64'd4294836225};

        // Reset, with a start request that reset must override.
        start = 1'b1; hsp_bands = 7'd5;
        repeat (3) @(negedge clk);
        chk("rst busy", longint'(busy), 0);
        chk("rst ready", longint'(band_ready), 0);
        chk("rst valid", longint'(mse_valid), 0);
        chk("rst value", longint'(mse_value), 0);
        chk("rst id", longint'(mse_id), 0);
        chk("rst error", longint'(error), 0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);

        // Table-driven constant-data jobs.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vecs[v].bands; i++) begin
                ref_arr[i] = 16'(vecs[v].ref_v);
                lib_arr[i] = 16'(vecs[v].lib_v);
            end
            run_job($sformatf("vec%0d", v), vecs[v].bands, vecs[v].id, -1, 0, -1,
                    MEAN ? vecs[v].mean : vecs[v].sse);
        end

        // Four bands with a two-cycle stall mid-stream.
        ref_arr[0] = 16'd10; ref_arr[1] = 16'd0; ref_arr[2] = 16'd16383; ref_arr[3] = 16'd7;
        lib_arr[0] = 16'd13; lib_arr[1] = 16'd0; lib_arr[2] = 16'd0;     lib_arr[3] = 16'd7;
        run_job("stall4", 4, 7, 2, 2, -1, MEAN ? 64'd67100674 : 64'd268402698);

        // Start during COMPUTE with a different id is ignored.
        run_job("ignstart", 4, 12, -1, 0, 1, MEAN ? 64'd67100674 : 64'd268402698);

        // Zero bands: error pulse, no activity.
        start = 1'b1; hsp_bands = 7'd0; hsp_id = 6'd9;
        @(negedge clk);
        start = 1'b0;
        chk("zero error_pulse", longint'(error), 1);
        chk("zero busy", longint'(busy), 0);
        @(negedge clk);
        chk("zero error_clears", longint'(error), 0);
        no_valid("zero no_valid", LAT + 10);

        // Clear after 2 of 4 bands.
        start = 1'b1; hsp_bands = 7'd4; hsp_id = 6'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            band_valid = 1'b1; hsp_ref = 16'd1000; hsp_lib = 16'd1;
            @(negedge clk);
        end
        band_valid = 1'b0;
        chk("clr id_before", longint'(mse_id), 3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr busy", longint'(busy), 0);
        chk("clr ready", longint'(band_ready), 0);
        chk("clr value", longint'(mse_value), 0);
        chk("clr id", longint'(mse_id), 0);
        chk("clr valid", longint'(mse_valid), 0);
        no_valid("clr no_valid", LAT + 10);
        ref_arr[0] = 16'd100; lib_arr[0] = 16'd40;
        run_job("after_clr", 1, 5, -1, 0, -1, 64'd3600);

        // Clear coinciding with the last band suppresses the result.
        start = 1'b1; hsp_bands = 7'd3; hsp_id = 6'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            band_valid = 1'b1; hsp_ref = 16'd500; hsp_lib = 16'd2;
            clear = (i == 2);
            @(negedge clk);
        end
        band_valid = 1'b0; clear = 1'b0;
        chk("clr_last busy", longint'(busy), 0);
        no_valid("clr_last no_valid", LAT + 10);

        // Randomized jobs against the reference model.
        for (int j = 0; j < 12; j++) begin
            int n = int'($urandom_range(1, 127));
            int sa = int'($urandom_range(0, 127));
            int sl = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) begin
                ref_arr[i] = 16'($urandom_range(0, 65535));
                lib_arr[i] = 16'($urandom_range(0, 65535));
            end
            run_job($sformatf("rand%0d", j), n, int'($urandom_range(0, 63)), sa, sl, -1, model(n));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
